// File: rtl/oam_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_master
// Brief    : Sprite DMA initiator; snoops the $4014 write, halts the CPU and
//            copies one 256-byte page to OAMDATA using get/put CPU cycles.
// Revision : 1.0  initial release
// ============================================================================
module oam_dma_master #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
    parameter int          XFER_LEN     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic        dma_cs,
    output logic        dma_rd,
    output logic        dma_wr,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_din,
    output logic [7:0]  dma_dout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_GET   = 3'd3,
        S_PUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] c_last_idx = 8'(XFER_LEN - 1);

    state_t      r_state;
    logic        r_parity;
    logic        r_first_put;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_data_q;
    logic        r_cpu_halt;
    logic        r_dma_active;
    logic        r_dma_cs;
    logic        r_dma_rd;
    logic        r_dma_wr;
    logic [15:0] r_dma_addr;

    logic        w_trigger;
    logic [7:0]  w_next_idx;

    assign w_trigger  = cpu_ce & cpu_wr & (cpu_addr == TRIGGER_ADDR);
    assign w_next_idx = r_idx + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_parity     <= 1'b0;
            r_first_put  <= 1'b0;
            r_page       <= 8'd0;
            r_idx        <= 8'd0;
            r_data_q     <= 8'd0;
            r_cpu_halt   <= 1'b0;
            r_dma_active <= 1'b0;
            r_dma_cs     <= 1'b1;
            r_dma_rd     <= 1'b0;
            r_dma_wr     <= 1'b0;
            r_dma_addr   <= 16'd0;
        end else begin
            r_first_put <= 1'b0;
            if (cpu_ce) begin
                r_parity <= ~r_parity;
            end
            // Memory data is only guaranteed during the first clk of PUT.
            if (r_first_put) begin
                r_data_q <= dma_din;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_page     <= cpu_dout;
                        r_cpu_halt <= 1'b1;
                        r_state    <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (cpu_ce) begin
                        r_dma_active <= 1'b1;
                        // Insert ALIGN when the next CPU cycle would be odd, so
                        // every GET lands on a parity-0 cycle.
                        if (!r_parity) begin
                            r_state <= S_ALIGN;
                        end else begin
                            r_state    <= S_GET;
                            r_dma_cs   <= 1'b0;
                            r_dma_rd   <= 1'b1;
                            r_dma_addr <= {r_page, r_idx};
                        end
                    end
                end
                S_ALIGN: begin
                    if (cpu_ce) begin
                        r_state    <= S_GET;
                        r_dma_cs   <= 1'b0;
                        r_dma_rd   <= 1'b1;
                        r_dma_addr <= {r_page, r_idx};
                    end
                end
                S_GET: begin
                    if (cpu_ce) begin
                        r_state     <= S_PUT;
                        r_dma_rd    <= 1'b0;
                        r_dma_wr    <= 1'b1;
                        r_dma_addr  <= OAMDATA_ADDR;
                        r_first_put <= 1'b1;
                    end
                end
                S_PUT: begin
                    if (cpu_ce) begin
                        r_idx    <= w_next_idx;
                        r_dma_wr <= 1'b0;
                        if (r_idx == c_last_idx) begin
                            r_state      <= S_DONE;
                            r_dma_active <= 1'b0;
                            r_dma_cs     <= 1'b1;
                        end else begin
                            r_state    <= S_GET;
                            r_dma_rd   <= 1'b1;
                            r_dma_addr <= {r_page, w_next_idx};
                        end
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_cpu_halt <= 1'b0;
                    r_idx      <= 8'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_halt   = r_cpu_halt;
    assign dma_active = r_dma_active;
    assign dma_cs     = r_dma_cs;
    assign dma_rd     = r_dma_rd;
    assign dma_wr     = r_dma_wr;
    assign dma_addr   = r_dma_addr;
    assign dma_dout   = r_first_put ? dma_din : r_data_q;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma_master
// Brief    : Self-checking bench: sync memory model, OAM write scoreboard,
//            table-driven and randomized transfers, reset-abort sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_oam_dma_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_halt;
    logic        dma_active;
    logic        dma_cs;
    logic        dma_rd;
    logic        dma_wr;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic [7:0]  dma_dout;

    oam_dma_master dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce     (cpu_ce),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_halt   (cpu_halt),
        .dma_active (dma_active),
        .dma_cs     (dma_cs),
        .dma_rd     (dma_rd),
        .dma_wr     (dma_wr),
        .dma_addr   (dma_addr),
        .dma_din    (dma_din),
        .dma_dout   (dma_dout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Synchronous memory: data appears one clk after a read address.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (!dma_cs && dma_rd) dma_din <= mem[dma_addr];
    end

    // cpu_ce generator: one pulse every ce_div clks.
    int ce_div   = 1;
    int ce_phase = 0;
    initial begin
        cpu_ce = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ce_phase = (ce_phase + 1 >= ce_div) ? 0 : ce_phase + 1;
            cpu_ce   = (ce_phase == 0);
        end
    end

    // Reference model, evaluated each negedge for the upcoming posedge.
    int         m_cnt   = 0;     // ce edges since reset; cycle parity = m_cnt % 2
    bit         m_busy  = 0;
    bit         m_done  = 0;
    logic [7:0] m_page  = 0;
    int         m_par   = 0;
    int         m_len   = 0;
    int         m_total = 0;
    int         m_rd    = 0;
    int         m_wr    = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_cnt  = 0;
                m_busy = 0;
                continue;
            end
            if (m_busy) begin
                if (cpu_ce) m_len++;
                if (cpu_ce && !dma_cs && dma_rd) begin
                    check("get_addr", {dma_active, dma_addr}, {1'b1, m_page, 8'(m_rd)});
                    check("get_parity", 64'(m_cnt % 2), 64'd0);
                    m_rd++;
                end
                if (cpu_ce && !dma_cs && dma_wr) begin
                    check("put", {dma_active, dma_addr, dma_dout},
                          {1'b1, 16'h2004, mem[{m_page, 8'(m_wr)}]});
                    m_wr++;
                    if (m_wr == 256) begin
                        m_busy  = 0;
                        m_done  = 1;
                        m_total = m_len;
                    end
                end
            end else begin
                check("bus_idle", {dma_active, dma_cs, dma_rd, dma_wr}, 4'b0100);
            end
            if (cpu_ce && cpu_wr && cpu_addr == 16'h4014 && !m_busy) begin
                m_busy = 1;
                m_done = 0;
                m_page = cpu_dout;
                m_par  = m_cnt % 2;
                m_len  = 0;
                m_rd   = 0;
                m_wr   = 0;
            end
            if (cpu_ce) m_cnt++;
        end
    end

    task automatic do_trigger(input logic [7:0] page, input int par, input bit chk_par);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(cpu_ce && (!chk_par || (m_cnt % 2) == par)) && n < 100);
        check("trigger_slot", 64'(n < 100), 64'd1);
        cpu_wr   = 1'b1;
        cpu_addr = 16'h4014;
        cpu_dout = page;
        @(posedge clk);
        #2;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic run_xfer(input logic [7:0] page, input int par, input int div,
                            input int retrig, input int exp_len);
        int n;
        ce_div = div;
        repeat (4) @(posedge clk);
        do_trigger(page, par, 1'b1);
        if (retrig >= 0) begin
            n = 0;
            while (m_wr < retrig && n < 2000) begin
                @(posedge clk);
                #2;
                n++;
            end
            do_trigger(8'h03, 0, 1'b0);
        end
        n = 0;
        while (!m_done && n < 2000 * div) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("xfer_done", 64'(m_done), 64'd1);
        check("xfer_len", 64'(m_total), 64'(exp_len));
        repeat (3) @(posedge clk);
        #2;
        check("released", {cpu_halt, dma_active, dma_cs, dma_rd, dma_wr}, 5'b00100);
    endtask

    typedef struct {
        logic [7:0] page;
        int         par;
        int         div;
        int         retrig;
        int         exp_len;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] rpage;
        int rpar;
        vecs[0] = '{8'h02, 0, 1, -1, 513};
        vecs[1] = '{8'h02, 1, 1, -1, 514};
        vecs[2] = '{8'h02, 0, 1, 40, 513};
        vecs[3] = '{8'hFF, 0, 3, -1, 513};
        vecs[4] = '{8'hFF, 1, 3, -1, 514};
        vecs[5] = '{8'h10, 1, 2, -1, 514};

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        rst      = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("reset_ctrl", {cpu_halt, dma_active, dma_cs, dma_rd, dma_wr}, 5'b00100);
        check("reset_addr", 64'(dma_addr), 64'd0);
        check("reset_dout", 64'(dma_dout), 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++)
            run_xfer(vecs[v].page, vecs[v].par, vecs[v].div, vecs[v].retrig, vecs[v].exp_len);

        // Reset during the PUT of idx 100, then a fresh transfer from page $04.
        ce_div = 1;
        repeat (4) @(posedge clk);
        do_trigger(8'h02, 0, 1'b0);
        n = 0;
        while (!(m_wr == 100 && dma_wr) && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("reach_idx100", 64'(n < 2000), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("abort_ctrl", {cpu_halt, dma_active, dma_cs, dma_rd, dma_wr}, 5'b00100);
        check("abort_dout", 64'(dma_dout), 64'd0);
        rst = 1'b0;
        run_xfer(8'h04, 0, 1, -1, 513);

        // A write to a neighbouring address must not start a transfer.
        @(posedge clk);
        #2;
        cpu_wr   = 1'b1;
        cpu_addr = 16'h4015;
        cpu_dout = 8'h07;
        repeat (2) @(posedge clk);
        #2;
        cpu_wr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("no_false_trigger", 64'(cpu_halt), 64'd0);

        for (int k = 0; k < 5; k++) begin
            rpage = 8'($urandom);
            rpar  = int'($urandom_range(0, 1));
            for (int i = 0; i < 256; i++) mem[{rpage, 8'(i)}] = 8'($urandom);
            run_xfer(rpage, rpar, int'($urandom_range(1, 3)), -1, 513 + rpar);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
